// File: rtl/eexp_seq.sv
// Sequential fixed-point e^x evaluator: sums the first TERMS Taylor terms, one term per clock,
// with valid/ready handshakes on both sides and optional clamping of the result.
module eexp_seq #(
    parameter int TOTAL_BITS      = 32,
    parameter int FRACTIONAL_BITS = 16,
    parameter int TERMS           = 5,
    parameter int SATURATE        = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [TOTAL_BITS-1:0] x,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [TOTAL_BITS-1:0] out,
    output logic                  overflow
);

    localparam int W  = 2 * TOTAL_BITS;
    localparam int PW = W + TOTAL_BITS;
    localparam int F  = FRACTIONAL_BITS;
    localparam int RW = F + 1;
    localparam int KW = $clog2(TERMS + 1);

    localparam logic [KW-1:0] K_FIRST = KW'(2);
    localparam logic [KW-1:0] K_LAST  = KW'(TERMS - 1);
    localparam logic [KW-1:0] K_STEP  = KW'(1);

    localparam logic [W-1:0]        UNIT    = W'(1);
    localparam logic signed [W-1:0] ONE     = UNIT << F;
    localparam logic signed [W-1:0] MAX_POS = (UNIT << (TOTAL_BITS - 1)) - UNIT;

    // Reciprocal table floor(2^F / k), built at elaboration; entries 0 and 1 are never read.
    function automatic logic [(TERMS+1)*RW-1:0] build_recip();
        logic [(TERMS+1)*RW-1:0] bits;
        bits = '0;
        for (int k = 2; k < TERMS; k++) begin
            bits[k*RW +: RW] = RW'((64'd1 << F) / 64'(k));
        end
        return bits;
    endfunction

    localparam logic [(TERMS+1)*RW-1:0] RECIP = build_recip();

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic signed [TOTAL_BITS-1:0] x_reg;
    logic signed [TOTAL_BITS-1:0] x_next;
    logic signed [W-1:0]          term;
    logic signed [W-1:0]          term_next;
    logic signed [W-1:0]          acc;
    logic signed [W-1:0]          acc_next;
    logic [KW-1:0]                k;
    logic [KW-1:0]                k_next;

    logic [RW-1:0]                recip_cur;
    logic signed [PW-1:0]         term_ext;
    logic signed [PW-1:0]         x_ext;
    logic signed [PW-1:0]         recip_ext;
    logic signed [PW-1:0]         t1;
    logic signed [W-1:0]          new_term;
    logic signed [W-1:0]          x_wide;

    logic [TOTAL_BITS-1:0]        res_out;
    logic                         res_ovf;
    logic                         finishing;

    // Two chained multiplies; the product width is wide enough that no bits are lost before the shifts.
    assign recip_cur = RECIP[int'(k)*RW +: RW];
    assign term_ext  = {{TOTAL_BITS{term[W-1]}}, term};
    assign x_ext     = {{W{x_reg[TOTAL_BITS-1]}}, x_reg};
    assign recip_ext = PW'(recip_cur);
    assign t1        = (term_ext * x_ext) >>> F;
    assign new_term  = W'((t1 * recip_ext) >>> F);
    assign x_wide    = {{TOTAL_BITS{x[TOTAL_BITS-1]}}, x};

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign finishing = (state_next == DONE) && (state != DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        x_next     = x_reg;
        term_next  = term;
        acc_next   = acc;
        k_next     = k;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    x_next     = x;
                    term_next  = x_wide;
                    acc_next   = ONE + x_wide;
                    k_next     = K_FIRST;
                    state_next = (TERMS > 2) ? RUN : DONE;
                end
            end
            RUN: begin
                term_next = new_term;
                acc_next  = acc + new_term;
                k_next    = k + K_STEP;
                if (k == K_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Truncated odd-degree series can dip below zero, so negative sums clamp to 0 without flagging.
    always_comb begin
        res_out = acc_next[TOTAL_BITS-1:0];
        res_ovf = 1'b0;
        if (SATURATE != 0) begin
            if (acc_next > MAX_POS) begin
                res_out = MAX_POS[TOTAL_BITS-1:0];
                res_ovf = 1'b1;
            end else if (acc_next[W-1]) begin
                res_out = '0;
            end
        end else begin
            res_ovf = (acc_next != {{TOTAL_BITS{acc_next[TOTAL_BITS-1]}}, acc_next[TOTAL_BITS-1:0]});
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            x_reg    <= '0;
            term     <= '0;
            acc      <= '0;
            k        <= '0;
            out      <= '0;
            overflow <= 1'b0;
        end else begin
            x_reg <= x_next;
            term  <= term_next;
            acc   <= acc_next;
            k     <= k_next;
            if (finishing) begin
                out      <= res_out;
                overflow <= res_ovf;
            end
        end
    end

endmodule

// File: tb/tb_eexp_seq.sv
// Scoreboard bench for eexp_seq: four instances with different TERMS/SATURATE settings,
// directed corner cases plus randomized arguments against a plain-arithmetic series model.
module tb_eexp_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        in_valid_v  [4];
    logic        in_ready_v  [4];
    logic        out_valid_v [4];
    logic        out_ready_v [4];
    logic        overflow_v  [4];
    logic [31:0] x_bus       [4];
    logic [31:0] out_v       [4];

    int terms_cfg [4] = '{5, 4, 5, 2};
    int sat_cfg   [4] = '{1, 1, 0, 1};

    typedef struct {
        int          dut;
        logic [31:0] out;
        logic        ov;
        longint      acc_cyc;
        string       name;
    } exp_t;

    exp_t   sb [$];
    logic   prev_valid [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    longint cyc = 0;
    bit     rand_bp = 1'b0;
    int     vectors = 0;
    int     miscompares = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    eexp_seq #(.TOTAL_BITS(32), .FRACTIONAL_BITS(16), .TERMS(5), .SATURATE(1)) u_a (
        .clock(clock), .reset(reset), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .x(x_bus[0]), .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .out(out_v[0]), .overflow(overflow_v[0]));

    eexp_seq #(.TOTAL_BITS(32), .FRACTIONAL_BITS(16), .TERMS(4), .SATURATE(1)) u_b (
        .clock(clock), .reset(reset), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .x(x_bus[1]), .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .out(out_v[1]), .overflow(overflow_v[1]));

    eexp_seq #(.TOTAL_BITS(32), .FRACTIONAL_BITS(16), .TERMS(5), .SATURATE(0)) u_c (
        .clock(clock), .reset(reset), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .x(x_bus[2]), .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
        .out(out_v[2]), .overflow(overflow_v[2]));

    eexp_seq #(.TOTAL_BITS(32), .FRACTIONAL_BITS(16), .TERMS(2), .SATURATE(1)) u_d (
        .clock(clock), .reset(reset), .in_valid(in_valid_v[3]), .in_ready(in_ready_v[3]),
        .x(x_bus[3]), .out_valid(out_valid_v[3]), .out_ready(out_ready_v[3]),
        .out(out_v[3]), .overflow(overflow_v[3]));

    function automatic void check(input string name, input longint act, input longint req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endfunction

    // Reference: sum the series term by term in 64-bit integers, then clamp or wrap.
    function automatic void model(input int d, input longint xv, output logic [31:0] o, output logic ov);
        longint term;
        longint acc;
        longint t1;
        longint one;
        longint max_pos;
        one     = 64'sd65536;
        max_pos = 64'sd2147483647;
        term    = xv;
        acc     = one + xv;
        for (int k = 2; k < terms_cfg[d]; k++) begin
            t1   = (term * xv) >>> 16;
            term = (t1 * (one / longint'(k))) >>> 16;
            acc  = acc + term;
        end
        o  = acc[31:0];
        ov = 1'b0;
        if (sat_cfg[d] != 0) begin
            if (acc > max_pos) begin
                o  = 32'h7FFF_FFFF;
                ov = 1'b1;
            end else if (acc < 0) begin
                o = 32'h0;
            end
        end else begin
            ov = (acc != longint'($signed(o)));
        end
    endfunction

    function automatic void check_dut(input int d);
        int   idx;
        exp_t e;
        if (out_valid_v[d]) begin
            idx = -1;
            for (int i = 0; i < sb.size(); i++) begin
                if (sb[i].dut == d) begin
                    idx = i;
                    break;
                end
            end
            if (idx < 0) begin
                check($sformatf("dut%0d_unexpected_valid", d), longint'(out_valid_v[d]), 0);
            end else begin
                e = sb[idx];
                check({e.name, "_out"}, longint'(out_v[d]), longint'(e.out));
                check({e.name, "_ovf"}, longint'(overflow_v[d]), longint'(e.ov));
                check({e.name, "_in_ready_low"}, longint'(in_ready_v[d]), 0);
                if (!prev_valid[d]) begin
                    check({e.name, "_latency"}, cyc - e.acc_cyc + 1, longint'(terms_cfg[d] - 1));
                end
                if (out_ready_v[d]) begin
                    sb.delete(idx);
                end
            end
        end
        prev_valid[d] = out_valid_v[d];
    endfunction

    // Monitor: samples one time unit after the falling edge, well away from the active edge.
    always begin
        @(negedge clock);
        #1;
        for (int d = 0; d < 4; d++) begin
            check_dut(d);
        end
    end

    always @(negedge clock) begin
        if (rand_bp) begin
            for (int d = 0; d < 4; d++) begin
                out_ready_v[d] = ($urandom_range(0, 2) != 0);
            end
        end
    end

    task automatic applyStimulus(input int d, input longint xv, input logic [31:0] eo,
                                 input logic eov, input string name);
        int n;
        @(negedge clock);
        in_valid_v[d] = 1'b1;
        x_bus[d]      = 32'(xv);
        n = 0;
        while (!in_ready_v[d] && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready_v[d]) begin
            check({name, "_accept_timeout"}, longint'(in_ready_v[d]), 1);
            in_valid_v[d] = 1'b0;
        end else begin
            sb.push_back('{d, eo, eov, cyc + 1, name});
            @(posedge clock);
            #1;
            in_valid_v[d] = 1'b0;
            x_bus[d]      = $urandom;
        end
    endtask

    task automatic applyModel(input int d, input longint xv, input string name);
        logic [31:0] eo;
        logic        eov;
        model(d, xv, eo, eov);
        applyStimulus(d, xv, eo, eov, name);
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(negedge clock);
            n++;
        end
        check({name, "_drain"}, longint'(sb.size()), 0);
    endtask

    task automatic checkOutput(input int d, input string name, input logic rdy, input logic vld);
        check({name, "_in_ready"}, longint'(in_ready_v[d]), longint'(rdy));
        check({name, "_out_valid"}, longint'(out_valid_v[d]), longint'(vld));
        check({name, "_out_zero"}, longint'(out_v[d]), 0);
        check({name, "_ovf_zero"}, longint'(overflow_v[d]), 0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        for (int d = 0; d < 4; d++) begin
            in_valid_v[d]  = 1'b0;
            out_ready_v[d] = 1'b1;
            x_bus[d]       = 32'h0;
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        for (int d = 0; d < 4; d++) begin
            checkOutput(d, $sformatf("reset_d%0d", d), 1'b1, 1'b0);
        end

        applyStimulus(0, 0, 32'd65536, 1'b0, "x0");
        applyStimulus(0, 65536, 32'd177492, 1'b0, "x1");
        applyStimulus(0, -65536, 32'd24575, 1'b0, "xm1");
        applyStimulus(0, 2621440, 32'h7FFF_FFFF, 1'b1, "x40_sat");
        applyStimulus(2, 2621440, 32'hCD9C_8B00, 1'b1, "x40_wrap");
        applyStimulus(1, -262144, 32'd0, 1'b0, "t4_xm4");
        applyStimulus(3, 65536, 32'd131072, 1'b0, "t2_x1");
        waitDrain("directed");

        // Hold the result under backpressure while a second argument is offered and refused.
        @(negedge clock);
        out_ready_v[0] = 1'b0;
        applyStimulus(0, 65536, 32'd177492, 1'b0, "bp_hold");
        n = 0;
        while (!out_valid_v[0] && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("bp_valid_seen", longint'(out_valid_v[0]), 1);
        repeat (10) begin
            @(negedge clock);
            in_valid_v[0] = 1'b1;
            x_bus[0]      = $urandom;
            #1;
            check("bp_in_ready", longint'(in_ready_v[0]), 0);
        end
        @(negedge clock);
        out_ready_v[0] = 1'b1;
        x_bus[0]       = 32'hFFFF_0000;
        sb.push_back('{0, 32'd24575, 1'b0, cyc + 2, "bp_next"});
        @(negedge clock);
        #1;
        check("bp_ready_after_release", longint'(in_ready_v[0]), 1);
        @(posedge clock);
        #1;
        in_valid_v[0] = 1'b0;
        waitDrain("backpressure");

        // Abort a computation mid-run with reset; nothing may come out of it.
        @(negedge clock);
        in_valid_v[0] = 1'b1;
        x_bus[0]      = 32'd65536;
        @(posedge clock);
        #1;
        in_valid_v[0] = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput(0, "abort", 1'b1, 1'b0);
        applyStimulus(0, 0, 32'd65536, 1'b0, "after_abort");
        waitDrain("abort");

        rand_bp = 1'b1;
        for (int d = 0; d < 4; d++) begin
            for (int i = 0; i < 20; i++) begin
                applyModel(d, longint'($urandom_range(0, 8388608)) - 64'sd4194304,
                           $sformatf("rnd_d%0d_%0d", d, i));
            end
        end
        waitDrain("random");
        rand_bp = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
